// File: rtl/max7219_pkg.sv
// Shared definitions for the MAX7219 display path: register map, state encoding
// and the driver word format.
package max7219_pkg;

  localparam logic [3:0] ADDR_DIGIT0       = 4'h1;
  localparam logic [3:0] ADDR_DECODE       = 4'h9;
  localparam logic [3:0] ADDR_INTENSITY    = 4'hA;
  localparam logic [3:0] ADDR_SCAN_LIMIT   = 4'hB;
  localparam logic [3:0] ADDR_SHUTDOWN     = 4'hC;
  localparam logic [3:0] ADDR_DISPLAY_TEST = 4'hF;

  localparam int INIT_LEN = 5;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_FRAME,
    ST_INTENS
  } state_t;

  // Driver word: upper nibble is don't-care on the chip and is always sent as zero.
  function automatic logic [15:0] mk_word(input logic [3:0] addr, input logic [7:0] data);
    return {4'h0, addr, data};
  endfunction

endpackage

// File: rtl/max7219_frame_sched.sv
// Sequences every MAX7219 register write: power-up configuration, full digit
// frames on update strobes, and intensity rewrites when brightness changes.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_INIT   | streaming the 5-word power-up sequence from the init ROM
// ST_IDLE   | nothing in flight; picks frame first, then intensity
// ST_FRAME  | streaming digit words 1..NUM_DIGITS from the snapshot
// ST_INTENS | single intensity word in flight
module max7219_frame_sched
  import max7219_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter logic [7:0] DECODE_MODE = 8'h00
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_en,
  input  logic                    i_update_stb,
  input  logic [8*NUM_DIGITS-1:0] i_digits,
  input  logic [3:0]              i_intensity,
  output logic [15:0]             o_word,
  output logic                    o_word_valid,
  input  logic                    i_word_ready,
  output logic                    o_busy,
  output logic                    o_init_done
);

  localparam logic [2:0] LAST_INIT  = 3'(INIT_LEN - 1);
  localparam logic [2:0] LAST_DIGIT = 3'(NUM_DIGITS - 1);

  state_t                  state, state_n;
  logic [2:0]              idx, idx_n, idx_inc;
  logic [8*NUM_DIGITS-1:0] frame_buf, frame_buf_n;
  logic                    frame_pending, pending_n;
  logic [3:0]              last_int, last_int_n;
  logic [15:0]             word_n;
  logic                    valid_n, init_done_n, busy_n;
  logic                    xfer;
  logic [3:0]              digit_addr;
  logic [7:0]              digit_byte;

  // Init ROM; the intensity entry carries the live brightness at load time.
  function automatic logic [15:0] init_rom(input logic [2:0] i, input logic [3:0] inten);
    case (i)
      3'd0:    return mk_word(ADDR_DISPLAY_TEST, 8'h00);
      3'd1:    return mk_word(ADDR_DECODE, DECODE_MODE);
      3'd2:    return mk_word(ADDR_SCAN_LIMIT, 8'(NUM_DIGITS - 1));
      3'd3:    return mk_word(ADDR_INTENSITY, {4'h0, inten});
      default: return mk_word(ADDR_SHUTDOWN, 8'h01);
    endcase
  endfunction

  assign xfer       = o_word_valid && i_word_ready;
  assign idx_inc    = idx + 3'd1;
  assign digit_addr = {1'b0, idx_inc} + ADDR_DIGIT0;
  assign digit_byte = frame_buf[{idx_inc, 3'b000} +: 8];

  // Next-state and next-output logic; every register defaults to holding.
  always_comb begin
    state_n     = state;
    idx_n       = idx;
    frame_buf_n = frame_buf;
    pending_n   = frame_pending | i_update_stb;
    last_int_n  = last_int;
    word_n      = o_word;
    valid_n     = o_word_valid;
    init_done_n = o_init_done;
    case (state)
      ST_INIT: begin
        if (!o_word_valid) begin
          word_n  = init_rom(idx, i_intensity);
          valid_n = 1'b1;
        end else if (xfer) begin
          if (o_word[11:8] == ADDR_INTENSITY) last_int_n = o_word[3:0];
          if (idx == LAST_INIT) begin
            valid_n     = 1'b0;
            idx_n       = 3'd0;
            init_done_n = 1'b1;
            state_n     = ST_IDLE;
          end else begin
            idx_n  = idx_inc;
            word_n = init_rom(idx_inc, i_intensity);
          end
        end
      end
      ST_IDLE: begin
        if (i_en) begin
          if (frame_pending || i_update_stb) begin
            frame_buf_n = i_digits;
            pending_n   = 1'b0;
            idx_n       = 3'd0;
            word_n      = mk_word(ADDR_DIGIT0, i_digits[7:0]);
            valid_n     = 1'b1;
            state_n     = ST_FRAME;
          end else if (i_intensity != last_int) begin
            word_n  = mk_word(ADDR_INTENSITY, {4'h0, i_intensity});
            valid_n = 1'b1;
            state_n = ST_INTENS;
          end
        end
      end
      ST_FRAME: begin
        if (xfer) begin
          if (idx == LAST_DIGIT) begin
            valid_n = 1'b0;
            idx_n   = 3'd0;
            state_n = ST_IDLE;
          end else begin
            idx_n  = idx_inc;
            word_n = mk_word(digit_addr, digit_byte);
          end
        end
      end
      ST_INTENS: begin
        if (xfer) begin
          last_int_n = o_word[3:0];
          valid_n    = 1'b0;
          state_n    = ST_IDLE;
        end
      end
      default: state_n = ST_INIT;
    endcase
    busy_n = (state_n != ST_IDLE);
  end

  // State and registered outputs; reset drops valid immediately and restarts init.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state         <= ST_INIT;
      idx           <= 3'd0;
      frame_buf     <= '0;
      frame_pending <= 1'b1;
      last_int      <= 4'h0;
      o_word        <= 16'h0000;
      o_word_valid  <= 1'b0;
      o_busy        <= 1'b1;
      o_init_done   <= 1'b0;
    end else begin
      state         <= state_n;
      idx           <= idx_n;
      frame_buf     <= frame_buf_n;
      frame_pending <= pending_n;
      last_int      <= last_int_n;
      o_word        <= word_n;
      o_word_valid  <= valid_n;
      o_busy        <= busy_n;
      o_init_done   <= init_done_n;
    end
  end

endmodule

// File: tb/tb_max7219_frame_sched.sv
// Self-checking bench for max7219_frame_sched: captures every transferred word
// and compares it against word lists built from the register-write rules.
module tb_max7219_frame_sched;

  localparam int ND = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            en = 1'b1;
  logic            stb = 1'b0;
  logic            ready = 1'b1;
  logic [8*ND-1:0] digits = '0;
  logic [3:0]      intensity = 4'h8;
  logic [15:0]     word;
  logic            valid, busy, init_done;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] got[$];
  logic [15:0] exp_q[$];
  bit          rand_ready = 1'b0;
  logic [3:0]  model_last = 4'h0;

  max7219_frame_sched #(.NUM_DIGITS(ND), .DECODE_MODE(8'h00)) dut (
    .i_clk(clk), .i_reset(rst), .i_en(en), .i_update_stb(stb),
    .i_digits(digits), .i_intensity(intensity),
    .o_word(word), .o_word_valid(valid), .i_word_ready(ready),
    .o_busy(busy), .o_init_done(init_done)
  );

  always #50 clk = ~clk;

  // A word sampled valid&&ready at the falling edge transfers on the next rising edge.
  always @(negedge clk) if (!rst && valid && ready) got.push_back(word);

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic wait_idle(output bit ok);
    int quiet = 0;
    ok = 1'b0;
    tick();
    for (int c = 0; c < 3000; c++) begin
      if (!busy && !valid) quiet++;
      else quiet = 0;
      if (quiet >= 3) begin ok = 1'b1; return; end
      tick();
    end
  endtask

  task automatic wait_words(input int n, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if (got.size() >= n) begin ok = 1'b1; return; end
      tick();
    end
  endtask

  function automatic logic [8*ND-1:0] rand_digits();
    return {$urandom(), $urandom()};
  endfunction

  task automatic exp_init(input logic [3:0] inten);
    exp_q.push_back(16'h0F00);
    exp_q.push_back(16'h0900);
    exp_q.push_back({8'h0B, 8'(ND - 1)});
    exp_q.push_back({8'h0A, 4'h0, inten});
    exp_q.push_back(16'h0C01);
  endtask

  task automatic exp_frame(input logic [8*ND-1:0] d);
    for (int n = 0; n < ND; n++) exp_q.push_back({4'h0, 4'(n + 1), d[8*n +: 8]});
  endtask

  task automatic strobe(input logic [8*ND-1:0] d);
    digits = d;
    stb = 1'b1;
    tick();
    stb = 1'b0;
  endtask

  task automatic test_reset();
    bit ok;
    bit seen4 = 1'b0;
    rst = 1'b1; ready = 1'b1; en = 1'b1; intensity = 4'h8; digits = rand_digits();
    tick(); tick();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got=%b exp=1", busy); end
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done got=%b exp=0", init_done); end
    checks++; if (word !== 16'h0000) begin errors++; $display("FAIL reset_word got=%h exp=0000", word); end
    got.delete(); exp_q.delete();
    rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (got.size() == 4 && !seen4) begin
        seen4 = 1'b1;
        checks++;
        if (init_done !== 1'b0) begin errors++; $display("FAIL init_done_early got=%b exp=0", init_done); end
      end
      if (got.size() == 5) begin
        checks++;
        if (init_done !== 1'b1) begin errors++; $display("FAIL init_done_rise got=%b exp=1", init_done); end
        break;
      end
    end
    checks++; if (!seen4) begin errors++; $display("FAIL init_progress got=%0d words exp=5", got.size()); end
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL reset_timeout got=busy exp=idle"); end
    exp_init(4'h8);
    exp_frame(digits);
    model_last = 4'h8;
    checks++;
    if (got.size() != exp_q.size()) begin errors++; $display("FAIL init_len got=%0d exp=%0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin errors++; $display("FAIL init_word[%0d] got=%h exp=%h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_frame();
    bit ok;
    logic [8*ND-1:0] d = rand_digits();
    got.delete(); exp_q.delete();
    strobe(d);
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL frame_latency_valid got=%b exp=1", valid); end
    checks++;
    if (word !== {8'h01, d[7:0]}) begin errors++; $display("FAIL frame_first_word got=%h exp=%h", word, {8'h01, d[7:0]}); end
    tick();
    digits = rand_digits();
    tick();
    digits = rand_digits();
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL frame_timeout got=busy exp=idle"); end
    exp_frame(d);
    checks++;
    if (got.size() != exp_q.size()) begin errors++; $display("FAIL frame_len got=%0d exp=%0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin errors++; $display("FAIL frame_word[%0d] got=%h exp=%h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [8*ND-1:0] d = rand_digits();
    logic [15:0] held;
    got.delete(); exp_q.delete();
    strobe(d);
    wait_words(3, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_start_timeout got=%0d exp=3", got.size()); end
    ready = 1'b0;
    held = {8'h04, d[31:24]};
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (valid !== 1'b1 || word !== held) begin
        errors++; $display("FAIL bp_hold cycle=%0d got=%b/%h exp=1/%h", c, valid, word, held);
      end
    end
    ready = 1'b1;
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_timeout got=busy exp=idle"); end
    exp_frame(d);
    checks++;
    if (got.size() != exp_q.size()) begin errors++; $display("FAIL bp_len got=%0d exp=%0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin errors++; $display("FAIL bp_word[%0d] got=%h exp=%h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_collision();
    bit ok;
    logic [8*ND-1:0] d1 = rand_digits();
    logic [8*ND-1:0] d2 = rand_digits();
    logic [8*ND-1:0] d3 = rand_digits();
    for (int pass = 0; pass < 2; pass++) begin
      got.delete(); exp_q.delete();
      strobe(d1);
      wait_words(2, ok);
      checks++; if (!ok) begin errors++; $display("FAIL coll_timeout_a got=%0d exp=2", got.size()); end
      strobe(d2);
      if (pass == 1) begin
        wait_words(5, ok);
        checks++; if (!ok) begin errors++; $display("FAIL coll_timeout_b got=%0d exp=5", got.size()); end
        strobe(d3);
      end
      wait_idle(ok);
      checks++; if (!ok) begin errors++; $display("FAIL coll_idle_timeout got=busy exp=idle"); end
      exp_frame(d1);
      exp_frame(pass == 1 ? d3 : d2);
      checks++;
      if (got.size() != exp_q.size()) begin errors++; $display("FAIL coll_len pass=%0d got=%0d exp=%0d", pass, got.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
        checks++;
        if (got[i] !== exp_q[i]) begin errors++; $display("FAIL coll_word[%0d] got=%h exp=%h", i, got[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_intensity();
    bit ok;
    logic [8*ND-1:0] d1 = rand_digits();
    logic [8*ND-1:0] d2 = rand_digits();
    logic [3:0] ni;
    got.delete(); exp_q.delete();
    intensity = 4'h3;
    wait_idle(ok);
    exp_q.push_back(16'h0A03);
    model_last = 4'h3;
    ni = 4'($urandom());
    while (ni == 4'h3) ni = 4'($urandom());
    strobe(d1);
    wait_words(3, ok);
    checks++; if (!ok) begin errors++; $display("FAIL int_timeout got=%0d exp=3", got.size()); end
    intensity = ni;
    strobe(d2);
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL int_idle_timeout got=busy exp=idle"); end
    exp_frame(d1);
    exp_frame(d2);
    exp_q.push_back({8'h0A, 4'h0, ni});
    model_last = ni;
    checks++;
    if (got.size() != exp_q.size()) begin errors++; $display("FAIL int_len got=%0d exp=%0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin errors++; $display("FAIL int_word[%0d] got=%h exp=%h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_enable();
    bit ok;
    logic [8*ND-1:0] d2 = rand_digits();
    got.delete(); exp_q.delete();
    en = 1'b0;
    strobe(rand_digits());
    for (int c = 0; c < 20; c++) tick();
    checks++; if (got.size() != 0) begin errors++; $display("FAIL en_blocked got=%0d exp=0", got.size()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL en_busy got=%b exp=0", busy); end
    digits = d2;
    en = 1'b1;
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL en_timeout got=busy exp=idle"); end
    exp_frame(d2);
    checks++;
    if (got.size() != exp_q.size()) begin errors++; $display("FAIL en_len got=%0d exp=%0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin errors++; $display("FAIL en_word[%0d] got=%h exp=%h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    bit ok;
    int op;
    logic [8*ND-1:0] d;
    logic [3:0] ni;
    rand_ready = 1'b1;
    for (int it = 0; it < 20; it++) begin
      got.delete(); exp_q.delete();
      op = $urandom_range(0, 2);
      d = rand_digits();
      ni = (op != 0) ? 4'($urandom()) : intensity;
      if (op != 1) exp_frame(d);
      if (ni != model_last) begin
        exp_q.push_back({8'h0A, 4'h0, ni});
        model_last = ni;
      end
      digits = d;
      intensity = ni;
      stb = (op != 1);
      tick();
      stb = 1'b0;
      wait_idle(ok);
      checks++; if (!ok) begin errors++; $display("FAIL rnd_timeout it=%0d got=busy exp=idle", it); end
      checks++;
      if (got.size() != exp_q.size()) begin errors++; $display("FAIL rnd_len it=%0d got=%0d exp=%0d", it, got.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
        checks++;
        if (got[i] !== exp_q[i]) begin errors++; $display("FAIL rnd_word it=%0d [%0d] got=%h exp=%h", it, i, got[i], exp_q[i]); end
      end
    end
    rand_ready = 1'b0;
    ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [8*ND-1:0] d2 = rand_digits();
    got.delete(); exp_q.delete();
    strobe(rand_digits());
    wait_words(3, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rmid_timeout got=%0d exp=3", got.size()); end
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rmid_valid_drop got=%b exp=0", valid); end
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL rmid_init_done got=%b exp=0", init_done); end
    got.delete();
    digits = d2;
    tick(); tick();
    rst = 1'b0;
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rmid_idle_timeout got=busy exp=idle"); end
    exp_init(intensity);
    exp_frame(d2);
    model_last = intensity;
    checks++;
    if (got.size() != exp_q.size()) begin errors++; $display("FAIL rmid_len got=%0d exp=%0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin errors++; $display("FAIL rmid_word[%0d] got=%h exp=%h", i, got[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_backpressure();
    test_collision();
    test_intensity();
    test_enable();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/max7219_frame_sched.md
# max7219_frame_sched

Scheduler that sequences all register writes to the MAX7219 display driver. After reset it issues the driver's power-up configuration sequence. It then streams a full digit frame whenever the clock core signals new display data, and re-issues the intensity register when brightness changes. It sits between the time/segment-encoding logic and the 16-bit serial shifter that drives `serial_load`/`serial_dout`/`serial_clk`.

## Interface
Parameters:
- `NUM_DIGITS`, 8, digits driven; legal range 1..8. Sets the scan-limit value and the frame length.
- `DECODE_MODE`, 8'h00, value written to the decode-mode register. 0 means raw segments.

Ports:
- `i_clk` in 1: system clock (~10 MHz).
- `i_reset` in 1: reset, **asynchronous, active-high**.
- `i_en` in 1: enable. Low blocks the start of new frames or intensity writes.
- `i_update_stb` in 1: one-cycle strobe meaning `i_digits` holds new content.
- `i_digits` in 8*NUM_DIGITS: segment byte for digit n at [8n+7:8n]. Bit 7 is DP; bits 6..0 are segments A..G.
- `i_intensity` in 4: display brightness, level-sampled.
- `o_word` out 16: driver word `{4'h0, addr[3:0], data[7:0]}`.
- `o_word_valid` out 1: `o_word` is valid.
- `i_word_ready` in 1: shifter accepts the word.
- `o_busy` out 1: high in any state other than IDLE.
- `o_init_done` out 1: high once the init sequence has completed. Stays high until reset.

## Operation
- **States:** INIT, IDLE, FRAME, INTENS.
- **Reset values:** state=INIT, `o_word`=0, `o_word_valid`=0, `o_busy`=1, `o_init_done`=0, frame_pending=1, last_intensity=0, word index=0.
- **INIT** sends 5 words in this order:
  1. 0x0F00: display test off.
  2. {0x09, DECODE_MODE}.
  3. {0x0B, NUM_DIGITS-1}: scan limit.
  4. {0x0A, 4'h0, i_intensity}: intensity.
  5. 0x0C01: normal operation.
  
  After the last transfer: last_intensity ← intensity sent, `o_init_done`=1, go to IDLE.
- INIT runs regardless of `i_en`.
- **IDLE** priority, evaluated each cycle when `i_en`=1:
  1. frame_pending, or `i_update_stb` this cycle → FRAME.
  2. `i_intensity` ≠ last_intensity → INTENS.
- **FRAME:**
  - On entry, snapshot `i_digits` into a frame buffer and clear frame_pending.
  - Send NUM_DIGITS words {n+1, buf[n]} for n = 0..NUM_DIGITS-1, in ascending order.
  - After the last transfer, go to IDLE.
- **INTENS:** send one word {0x0A, 4'h0, i_intensity}. On transfer: last_intensity ← value sent, go to IDLE.
- **Strobe while busy:** `i_update_stb` in INIT, FRAME or INTENS sets frame_pending. The frame in flight is not altered, so it always completes with its snapshot data.
- **Intensity change during a frame:** not preempted. It is picked up in IDLE after any pending frame.
- **`i_en` low:** an in-progress sequence completes; no new FRAME/INTENS starts. A strobe arriving while `i_en`=0 still sets frame_pending.
- **Reset mid-sequence:** all state is dropped immediately (`o_word_valid`=0 asynchronously) and INIT restarts.

## Timing
- **Valid/ready:** a word transfers on a rising edge with `o_word_valid`&&`i_word_ready`.
  - While valid is high and ready is low, `o_word` holds stable.
  - `o_word_valid` never drops without a transfer, except on reset.
- **Back-to-back:** on a transfer edge, the next word of the same sequence is registered. Valid stays high, giving 1 word/cycle when ready is held high.
- **Sequence end:** on the last transfer edge, valid drops with the transition to IDLE.
- **Start latency:** with `i_update_stb` high in IDLE at edge k, FRAME is entered at edge k. The digit-0 word is valid from edge k until transfer. The snapshot is `i_digits` as sampled at edge k.
- **Intensity latency:** change seen at edge k in IDLE → word valid after edge k.
- **Minimum durations** (ready always high): init takes 5 cycles; a full frame takes NUM_DIGITS cycles.
- **Outputs:** all are registered; there is no combinational path from `i_word_ready` to any output.

## Structure
- Shared package `max7219_pkg`:
  - Register addresses: DIGIT0=1, DECODE=0x09, INTENSITY=0x0A, SCAN_LIMIT=0x0B, SHUTDOWN=0x0C, DISPLAY_TEST=0x0F.
  - State enum.
  - Function `mk_word(addr, data)`.
- The init sequence is a constant ROM indexed by the word counter, held inside this block.
- Natural sub-module: `max7219_word_tx`, the 16-bit shifter consuming `o_word`/`o_word_valid`/`i_word_ready` and producing load/din/clk. It is built and verified separately; this block does not instantiate it.

## Test plan
- **Reset/init:** release reset with ready=1 and `i_intensity`=4'h8.
  - Required words: 0x0F00, 0x0900, 0x0B07, 0x0A08, 0x0C01, then 8 digit words 0x01xx..0x08xx.
  - `o_init_done` rises on the edge of the 5th transfer.
- **Frame:** `i_digits`={8'h7E,8'h30,...} with strobe in IDLE.
  - Digit-0 word appears the cycle after the strobe edge.
  - Addresses 1..8 in order with the snapshot bytes.
  - Changing `i_digits` mid-frame does not alter the emitted words.
- **Backpressure:** ready low for 10 cycles mid-frame.
  - `o_word` is constant and valid stays high.
  - Ordering and count resume correctly when ready returns.
- **Strobe collision:** strobe during word 3 of a frame.
  - Exactly one further frame follows immediately, carrying the new data.
  - Two strobes during the frame still yield only one further frame.
- **Intensity:** change 8→3 in IDLE → single word 0x0A03. A change during a frame with a pending strobe gives frame, then frame, then 0x0A03.
- **Enable/reset:**
  - `i_en`=0 with a strobe → no words; raising `i_en` → frame starts.
  - `i_reset` asserted mid-frame → valid drops immediately, and after release the init sequence restarts at 0x0F00.
